// File: rtl/logic_reduce_pipe.sv
// Run-time selectable AND/OR/XOR/NAND reduction across NUM_IN lanes, followed by
// a DEPTH-stage registered pipeline with valid tracking, stall, flush and a saturating result counter.
module logic_reduce_pipe #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic [1:0]              op,
    input  logic                    in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        out_cnt
);

    generate
        if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
            $error("logic_reduce_pipe: NUM_IN must be in 2..16");
        end
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("logic_reduce_pipe: DEPTH must be in 1..8");
        end
        if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
            $error("logic_reduce_pipe: WIDTH and CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    op_e              op_sel;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] red;

    assign op_sel = op_e'(op);

    always_comb begin
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            and_r = and_r & in_data[i*WIDTH +: WIDTH];
            or_r  = or_r  | in_data[i*WIDTH +: WIDTH];
            xor_r = xor_r ^ in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        red = and_r;
        case (op_sel)
            OP_AND:  red = and_r;
            OP_OR:   red = or_r;
            OP_XOR:  red = xor_r;
            OP_NAND: red = ~and_r;
            default: red = and_r;
        endcase
    end

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] src_data   [DEPTH];
    logic [DEPTH-1:0] src_valid;

    // Each stage is fed by the reduction (stage 0) or by the stage before it.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign src_data[k]  = red;
                assign src_valid[k] = in_valid;
            end else begin : g_body
                assign src_data[k]  = stage_data[k-1];
                assign src_valid[k] = stage_valid[k-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_data[k]  <= '0;
                    stage_valid[k] <= 1'b0;
                end else begin
                    if (en) begin
                        stage_data[k] <= src_data[k];
                    end
                    // Flush only touches valid flags; data keeps following en.
                    if (flush) begin
                        stage_valid[k] <= 1'b0;
                    end else if (en) begin
                        stage_valid[k] <= src_valid[k];
                    end
                end
            end
        end
    endgenerate

    logic final_load;

    assign final_load = en && !flush && src_valid[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (final_load && !(&out_cnt)) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Directed bench for logic_reduce_pipe: four instances cover defaults, reduction ops,
// stall, flush, counter saturation and reset-in-flight.
module tb_logic_reduce_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    // Defaults: WIDTH=1, NUM_IN=2, DEPTH=2, CNT_W=16
    logic        d_rst, d_en, d_flush, d_in_valid, d_out_valid;
    logic [1:0]  d_op, d_in_data;
    logic [0:0]  d_out_data;
    logic [15:0] d_out_cnt;

    // WIDTH=4, NUM_IN=3, DEPTH=2
    logic        x_rst, x_en, x_flush, x_in_valid, x_out_valid;
    logic [1:0]  x_op;
    logic [11:0] x_in_data;
    logic [3:0]  x_out_data;
    logic [15:0] x_out_cnt;

    // WIDTH=4, NUM_IN=2, DEPTH=3
    logic        s_rst, s_en, s_flush, s_in_valid, s_out_valid;
    logic [1:0]  s_op;
    logic [7:0]  s_in_data;
    logic [3:0]  s_out_data;
    logic [15:0] s_out_cnt;

    // WIDTH=4, NUM_IN=2, DEPTH=4, CNT_W=3
    logic        f_rst, f_en, f_flush, f_in_valid, f_out_valid;
    logic [1:0]  f_op;
    logic [7:0]  f_in_data;
    logic [3:0]  f_out_data;
    logic [2:0]  f_out_cnt;

    logic_reduce_pipe u_def (
        .clk(clk), .rst(d_rst), .en(d_en), .flush(d_flush), .op(d_op),
        .in_valid(d_in_valid), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_data(d_out_data), .out_cnt(d_out_cnt)
    );

    logic_reduce_pipe #(.WIDTH(4), .NUM_IN(3), .DEPTH(2)) u_x (
        .clk(clk), .rst(x_rst), .en(x_en), .flush(x_flush), .op(x_op),
        .in_valid(x_in_valid), .in_data(x_in_data),
        .out_valid(x_out_valid), .out_data(x_out_data), .out_cnt(x_out_cnt)
    );

    logic_reduce_pipe #(.WIDTH(4), .NUM_IN(2), .DEPTH(3)) u_s (
        .clk(clk), .rst(s_rst), .en(s_en), .flush(s_flush), .op(s_op),
        .in_valid(s_in_valid), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_cnt(s_out_cnt)
    );

    logic_reduce_pipe #(.WIDTH(4), .NUM_IN(2), .DEPTH(4), .CNT_W(3)) u_f (
        .clk(clk), .rst(f_rst), .en(f_en), .flush(f_flush), .op(f_op),
        .in_valid(f_in_valid), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_data(f_out_data), .out_cnt(f_out_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [1:0] x_ops [4];
    logic [3:0] x_exp [4];

    initial begin
        x_ops = '{2'b10, 2'b11, 2'b00, 2'b01};
        x_exp = '{4'h6, 4'hD, 4'h2, 4'hF};

        d_rst = 1'b1; d_en = 1'b1; d_flush = 1'b0; d_op = 2'b00; d_in_valid = 1'b0; d_in_data = '0;
        x_rst = 1'b1; x_en = 1'b1; x_flush = 1'b0; x_op = 2'b00; x_in_valid = 1'b0; x_in_data = '0;
        s_rst = 1'b1; s_en = 1'b1; s_flush = 1'b0; s_op = 2'b01; s_in_valid = 1'b0; s_in_data = '0;
        f_rst = 1'b1; f_en = 1'b1; f_flush = 1'b0; f_op = 2'b01; f_in_valid = 1'b0; f_in_data = '0;
        tick();
        tick();
        check("rst_def_valid", d_out_valid, 0);
        check("rst_def_data",  d_out_data,  0);
        check("rst_def_cnt",   d_out_cnt,   0);
        check("rst_f_cnt",     f_out_cnt,   0);
        d_rst = 1'b0; x_rst = 1'b0; s_rst = 1'b0; f_rst = 1'b0;

        // Defaults: legacy AND plus two flops
        d_in_valid = 1'b1; d_in_data = 2'b11;
        tick();
        check("def_lat_valid0", d_out_valid, 0);
        d_in_valid = 1'b0; d_in_data = 2'b00;
        tick();
        check("def_out_valid", d_out_valid, 1);
        check("def_out_data",  d_out_data,  1);
        check("def_out_cnt",   d_out_cnt,   1);
        tick();
        check("def_drain_valid", d_out_valid, 0);
        check("def_drain_data",  d_out_data,  0);
        check("def_drain_cnt",   d_out_cnt,   1);

        // All four ops on {F,A,3}, op switched every cycle
        for (int i = 0; i < 4; i++) begin
            x_op = x_ops[i]; x_in_valid = 1'b1; x_in_data = 12'hFA3;
            tick();
            if (i > 0) begin
                check("op_data",  x_out_data,  x_exp[i-1]);
                check("op_valid", x_out_valid, 1);
            end
        end
        x_in_valid = 1'b0;
        tick();
        check("op_last_data", x_out_data, x_exp[3]);
        tick();
        check("op_drain_valid", x_out_valid, 0);
        check("op_cnt", x_out_cnt, 4);

        // Stall: two stall cycles after the second sample, then one with output valid
        s_in_valid = 1'b1; s_in_data = 8'h01;
        tick();
        s_in_data = 8'h02;
        tick();
        check("stall_pre_valid", s_out_valid, 0);
        s_en = 1'b0; s_in_data = 8'h09;
        tick();
        check("stall1_valid", s_out_valid, 0);
        tick();
        check("stall2_valid", s_out_valid, 0);
        check("stall2_cnt",   s_out_cnt,   0);
        s_en = 1'b1; s_in_data = 8'h03;
        tick();
        check("stall_s1_data",  s_out_data,  1);
        check("stall_s1_valid", s_out_valid, 1);
        check("stall_s1_cnt",   s_out_cnt,   1);
        s_in_valid = 1'b0; s_in_data = 8'h00;
        tick();
        check("stall_s2_data", s_out_data, 2);
        check("stall_s2_cnt",  s_out_cnt,  2);
        s_en = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h09;
        tick();
        check("stall_hold_data",  s_out_data,  2);
        check("stall_hold_valid", s_out_valid, 1);
        check("stall_hold_cnt",   s_out_cnt,   2);
        s_en = 1'b1; s_in_valid = 1'b0; s_in_data = 8'h00;
        tick();
        check("stall_s3_data",  s_out_data,  3);
        check("stall_s3_valid", s_out_valid, 1);
        check("stall_s3_cnt",   s_out_cnt,   3);
        tick();
        check("stall_end_valid", s_out_valid, 0);
        check("stall_end_cnt",   s_out_cnt,   3);

        // Flush with three samples in flight plus one issued in the flush cycle
        f_in_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            f_in_data = 8'(v);
            tick();
        end
        f_flush = 1'b1; f_in_data = 8'h04;
        tick();
        check("flush_valid", f_out_valid, 0);
        check("flush_cnt",   f_out_cnt,   0);
        f_flush = 1'b0; f_in_valid = 1'b0; f_in_data = 8'h00;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("flush_after_valid", f_out_valid, 0);
        end
        check("flush_after_cnt", f_out_cnt, 0);

        // Saturation at 7 with CNT_W=3
        for (int i = 0; i < 10; i++) begin
            f_in_valid = 1'b1; f_in_data = 8'(i + 1);
            tick();
            if (i == 3) begin
                check("sat_first_data",  f_out_data,  1);
                check("sat_first_valid", f_out_valid, 1);
                check("sat_first_cnt",   f_out_cnt,   1);
            end
        end
        check("sat_cnt7",  f_out_cnt,  7);
        check("sat_data7", f_out_data, 7);
        f_in_data = 8'h0B;
        tick();
        tick();
        check("sat_hold_cnt", f_out_cnt, 7);
        f_rst = 1'b1; f_en = 1'b0;
        tick();
        check("sat_rst_valid", f_out_valid, 0);
        check("sat_rst_data",  f_out_data,  0);
        check("sat_rst_cnt",   f_out_cnt,   0);
        f_rst = 1'b0; f_en = 1'b1; f_in_valid = 1'b0; f_in_data = 8'h00;
        tick();
        check("sat_post_rst_valid", f_out_valid, 0);

        // Reset with en=0 and flush=1 while two samples are in flight
        s_in_valid = 1'b1; s_in_data = 8'h05;
        tick();
        s_in_data = 8'h06;
        tick();
        s_rst = 1'b1; s_en = 1'b0; s_flush = 1'b1; s_in_data = 8'h07;
        tick();
        check("rif_valid", s_out_valid, 0);
        check("rif_data",  s_out_data,  0);
        check("rif_cnt",   s_out_cnt,   0);
        s_rst = 1'b0; s_en = 1'b1; s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h08;
        tick();
        s_in_valid = 1'b0; s_in_data = 8'h00;
        check("rif_lat0_valid", s_out_valid, 0);
        tick();
        check("rif_lat1_valid", s_out_valid, 0);
        tick();
        check("rif_new_valid", s_out_valid, 1);
        check("rif_new_data",  s_out_data,  8);
        check("rif_new_cnt",   s_out_cnt,   1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
- Parametrised successor to the fixed two-input AND, two-flop-delay cell netlist.
- Performs a lane-wise logic reduction (AND/OR/XOR/NAND, selected at run time) across NUM_IN input vectors of WIDTH bits each.
- Registers the result through a DEPTH-stage pipeline with valid tracking, global stall, flush and a saturating output counter.
- Used wherever a registered, delay-matched gate-level combine is required.
- Defaults (WIDTH=1, NUM_IN=2, DEPTH=2, op=AND, en=1) are cycle-equivalent to the legacy AND-plus-two-flop chain.

Parameters:
- WIDTH, 1, bits per lane; in_data/out_data lane width.
- NUM_IN, 2, number of input vectors reduced; legal range 2..16.
- DEPTH, 2, number of pipeline register stages; legal range 1..8.
- CNT_W, 16, width of the output-event counter.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 = stall, all stages hold.
- flush  input  1  clears all valid flags in the pipeline.
- op  input  2  reduction select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- in_valid  input  1  marks in_data as a valid sample.
- in_data  input  NUM_IN*WIDTH  input vector i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  final-stage valid flag.
- out_data  output  WIDTH  final-stage reduced data.
- out_cnt  output  CNT_W  number of valid results delivered, saturating.

Behaviour:
- Reduction (combinational, ahead of stage 0), per bit b: r[b] = OP over i=0..NUM_IN-1 of in_data[i*WIDTH+b].
  - NAND = inverted AND-reduce.
  - op is sampled together with in_data; a change of op affects only samples entering stage 0 in that cycle.
- Pipeline: stages S0..S(DEPTH-1), each holding {valid, data[WIDTH-1:0]}.
  - Outputs: out_data = S(DEPTH-1).data, out_valid = S(DEPTH-1).valid.
  - When en=1: S0 <= {in_valid, r} and Sk <= S(k-1) for k>=1.
  - Data registers load whether or not the valid flag is set (free-running data path, matching the legacy flops).
- Latency: with en held 1, a sample presented at edge t appears on out_data/out_valid after edge t+DEPTH-1, i.e. DEPTH clocks from capture.
  - Throughput is one sample per cycle.
- Stall: en=0 holds every stage's data and valid, including the outputs. in_data and in_valid are ignored that cycle; the sample is lost and upstream must hold it.
- Flush: flush=1 clears every stage's valid flag at the next edge, regardless of en.
  - Data registers follow the en rule unchanged.
  - If en=1 and flush=1 together, S0.valid is also cleared, so the incoming sample is discarded.
- Counter: out_cnt increments by 1 at each edge where the final stage loads valid=1.
  - Load condition: en=1, flush=0, and the source valid = 1. The source is S(DEPTH-2).valid, or in_valid when DEPTH=1.
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - flush does not clear out_cnt.
- Reset (rst=1 at an edge): all stage data=0, all valid=0, out_cnt=0.
  - Outputs after reset: out_valid=0, out_data=0, out_cnt=0.
  - rst overrides en and flush.
  - Reset in mid-stream discards all in-flight samples. The first post-reset sample obeys normal latency.
- Priority: rst > flush (valid flags only) > en.
- Illegal parameter values (NUM_IN<2, DEPTH<1) must fail elaboration.

Test Plan:
- Defaults, in_valid=1, in_data=2'b11 for one cycle and 2'b00 otherwise -> out_data=1 and out_valid=1 exactly 2 clocks after capture; out_cnt=1.
- WIDTH=4, NUM_IN=3, op=XOR, in_data={4'hF,4'hA,4'h3} -> out_data=4'h6. With op=NAND on the same data -> 4'hD, DEPTH cycles later.
- DEPTH=3, stream valid samples 1,2,3 with en=0 for 2 cycles after the second sample -> outputs stay frozen during the stall. All three samples emerge in order with no duplicates; out_cnt=3.
- DEPTH=4, three valid samples in flight, assert flush with en=1 -> out_valid stays 0 for the next 4 cycles and out_cnt is unchanged. A sample issued in the flush cycle is discarded.
- CNT_W=3, 10 consecutive valid samples -> out_cnt reaches 7 and holds 7; a subsequent rst returns out_cnt=0, out_valid=0, out_data=0 on the next edge.
- rst asserted while 2 samples are in flight with en=0 and flush=1 simultaneously -> all state cleared at that edge. A new sample after rst deasserts appears after DEPTH clocks.
